// File: rtl/riscv_pkg.sv
// Shared constants and types for the MEM/WB pipeline slice: widths,
// the data-memory handshake state and the EX/MEM pipeline slot.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int RA_W = 5;

   typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT} mstate_e;

   typedef struct packed {
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] wdata;
      logic [RA_W-1:0] rd;
      logic            RegWrite;
      logic            MemRead;
      logic            MemWrite;
      logic            MemtoReg;
      logic            valid;
   } slot_t;

   function automatic logic is_memop(slot_t s);
      return s.valid & (s.MemRead | s.MemWrite);
   endfunction
endpackage

// File: rtl/mem_wb_pipe_if.sv
// Data-memory request/grant/response bus between the MEM stage and memory.
interface mem_wb_pipe_if;
   import riscv_pkg::*;

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_wb_pipe_dmem_fsm.sv
// Data-memory handshake engine: issues the request, tracks grant and
// response, and reports the cycle in which the MEM operation completes.
module dmem_if_fsm
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            memop_i,
   input  logic            store_i,
   input  logic            gnt_i,
   input  logic            rvalid_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic            req_o,
   output logic            complete_o,
   output logic [XLEN-1:0] ldata_o
);
   mstate_e state_q, state_d, cur;

   // A fresh memory op in IDLE behaves as REQ in the same cycle.
   always_comb begin
      cur        = state_q;
      state_d    = M_IDLE;
      complete_o = 1'b0;
      if (state_q == M_IDLE && memop_i) cur = M_REQ;
      req_o = memop_i && (cur == M_REQ);
      case (cur)
         M_REQ: begin
            if (!memop_i) begin
               state_d = M_IDLE;
            end else if (gnt_i) begin
               if (store_i || rvalid_i) complete_o = 1'b1;
               else                     state_d    = M_WAIT;
            end else begin
               state_d = M_REQ;
            end
         end
         M_WAIT: begin
            if (memop_i && rvalid_i) complete_o = 1'b1;
            else if (memop_i)        state_d    = M_WAIT;
         end
         default: state_d = M_IDLE;
      endcase
   end

   // Load data is only meaningful in the completing cycle of a load.
   assign ldata_o = (complete_o && !store_i) ? rdata_i : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= M_IDLE;
      else        state_q <= state_d;
   end
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM stage: EX/MEM and MEM/WB pipeline registers, data-memory access
// and the stall that freezes upstream while a load/store is in flight.
module mem_wb_pipe #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int RA_W = riscv_pkg::RA_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] ALUResult_ex,
   input  logic [XLEN-1:0] MemWriteData_ex,
   input  logic [RA_W-1:0] rdAddr_ex,
   input  logic            RegWrite_ex,
   input  logic            MemRead_ex,
   input  logic            MemWrite_ex,
   input  logic            MemtoReg_ex,
   input  logic            valid_ex,
   input  logic            flush_ex,
   mem_wb_pipe_if.master   dmem,
   output logic            stall_mem,
   output logic [XLEN-1:0] ALUResult_mem,
   output logic [RA_W-1:0] rdAddr_mem,
   output logic            RegWrite_mem,
   output logic            MemRead_mem,
   output logic [XLEN-1:0] RegWriteData_wb,
   output logic [RA_W-1:0] rdAddr_wb,
   output logic            RegWrite_wb
);
   import riscv_pkg::*;

   slot_t           mem_d, mem_q;
   logic            ex_live, memop, complete;
   logic [XLEN-1:0] ldata, wbdata_d, wbdata_q;
   logic [RA_W-1:0] wbrd_q;
   logic            wbrw_d, wbrw_q;

   // A flushed or invalid EX slot enters MEM as a bubble.
   always_comb begin
      ex_live        = valid_ex & ~flush_ex;
      mem_d.alu      = ALUResult_ex;
      mem_d.wdata    = MemWriteData_ex;
      mem_d.rd       = rdAddr_ex;
      mem_d.RegWrite = RegWrite_ex & ex_live;
      mem_d.MemRead  = MemRead_ex & ex_live;
      mem_d.MemWrite = MemWrite_ex & ex_live;
      mem_d.MemtoReg = MemtoReg_ex;
      mem_d.valid    = ex_live;
   end

   assign memop     = is_memop(mem_q);
   assign stall_mem = memop & ~complete;

   dmem_if_fsm u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .memop_i    (memop),
      .store_i    (mem_q.MemWrite),
      .gnt_i      (dmem.dmem_gnt),
      .rvalid_i   (dmem.dmem_rvalid),
      .rdata_i    (dmem.dmem_rdata),
      .req_o      (dmem.dmem_req),
      .complete_o (complete),
      .ldata_o    (ldata)
   );

   assign dmem.dmem_we    = mem_q.MemWrite;
   assign dmem.dmem_addr  = mem_q.alu;
   assign dmem.dmem_wdata = mem_q.wdata;

   assign ALUResult_mem = mem_q.alu;
   assign rdAddr_mem    = mem_q.rd;
   assign RegWrite_mem  = mem_q.RegWrite & mem_q.valid & (mem_q.rd != '0);
   assign MemRead_mem   = mem_q.MemRead;

   // While stalled, WB receives a bubble so nothing is written twice.
   assign wbdata_d = mem_q.MemtoReg ? ldata : mem_q.alu;
   assign wbrw_d   = RegWrite_mem & ~stall_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wbdata_q <= '0;
         wbrd_q   <= '0;
         wbrw_q   <= 1'b0;
      end else begin
         if (!stall_mem) mem_q <= mem_d;
         wbdata_q <= wbdata_d;
         wbrd_q   <= mem_q.rd;
         wbrw_q   <= wbrw_d;
      end
   end

   assign RegWriteData_wb = wbdata_q;
   assign rdAddr_wb       = wbrd_q;
   assign RegWrite_wb     = wbrw_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus a randomized
// stream checked every cycle against a transaction-level reference model.
module tb_mem_wb_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] ALUResult_ex = '0, MemWriteData_ex = '0;
   logic [4:0]  rdAddr_ex = '0;
   logic        RegWrite_ex = 0, MemRead_ex = 0, MemWrite_ex = 0, MemtoReg_ex = 0;
   logic        valid_ex = 0, flush_ex = 0;
   logic        stall_mem, RegWrite_mem, MemRead_mem, RegWrite_wb;
   logic [31:0] ALUResult_mem, RegWriteData_wb;
   logic [4:0]  rdAddr_mem, rdAddr_wb;

   mem_wb_pipe_if dif();

   always #5 clk = ~clk;

   mem_wb_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
      .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
      .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
      .valid_ex(valid_ex), .flush_ex(flush_ex), .dmem(dif),
      .stall_mem(stall_mem), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
      .RegWrite_mem(RegWrite_mem), .MemRead_mem(MemRead_mem),
      .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb)
   );

   int n_chk = 0, n_pass = 0;

   // Reference model: the instruction sitting in MEM, whether its request
   // has already been granted, and the last write-back.
   logic        m_v, m_rw, m_mr, m_mw, m_m2r, m_gr;
   logic [31:0] m_alu, m_wd;
   logic [4:0]  m_rd;
   logic        m_wbrw;
   logic [4:0]  m_wbrd;
   logic [31:0] m_wbdata;
   logic        obs_stall, obs_req;
   logic [31:0] obs_addr, obs_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_gr = 0;
      m_alu = '0; m_wd = '0; m_rd = '0;
      m_wbrw = 0; m_wbrd = '0; m_wbdata = '0;
   endtask

   function automatic logic exp_req();
      return m_v & (m_mr | m_mw) & ~m_gr;
   endfunction

   task automatic step(input logic v, input logic fl, input logic rw, input logic mr,
                       input logic mw, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic g, input logic rv,
                       input logic [31:0] rdt);
      logic memop, cmp, stall, rwm, live;
      @(negedge clk);
      valid_ex = v; flush_ex = fl; RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw;
      MemtoReg_ex = mr; rdAddr_ex = rd; ALUResult_ex = alu; MemWriteData_ex = wd;
      dif.dmem_gnt = g; dif.dmem_rvalid = rv; dif.dmem_rdata = rdt;
      #1;
      memop = m_v & (m_mr | m_mw);
      cmp   = memop & (m_mw ? g : ((m_gr | g) & rv));
      stall = memop & ~cmp;
      rwm   = m_v & m_rw & (m_rd != 5'd0);
      chk("stall_mem", 32'(stall_mem), 32'(stall));
      chk("dmem_req", 32'(dif.dmem_req), 32'(exp_req()));
      if (exp_req()) begin
         chk("dmem_we", 32'(dif.dmem_we), 32'(m_mw));
         chk("dmem_addr", dif.dmem_addr, m_alu);
         if (m_mw) chk("dmem_wdata", dif.dmem_wdata, m_wd);
      end
      chk("ALUResult_mem", ALUResult_mem, m_alu);
      chk("rdAddr_mem", 32'(rdAddr_mem), 32'(m_rd));
      chk("RegWrite_mem", 32'(RegWrite_mem), 32'(rwm));
      chk("MemRead_mem", 32'(MemRead_mem), 32'(m_mr));
      chk("RegWrite_wb", 32'(RegWrite_wb), 32'(m_wbrw));
      chk("rdAddr_wb", 32'(rdAddr_wb), 32'(m_wbrd));
      if (m_wbrw) chk("RegWriteData_wb", RegWriteData_wb, m_wbdata);
      obs_stall = stall_mem; obs_req = dif.dmem_req;
      obs_addr = dif.dmem_addr; obs_wdata = dif.dmem_wdata;
      @(posedge clk);
      m_wbrw = rwm & ~stall;
      m_wbrd = m_rd;
      if (!stall) m_wbdata = m_m2r ? rdt : m_alu;
      if (stall) begin
         m_gr = m_gr | g;
      end else begin
         live = v & ~fl;
         m_gr = 0; m_v = live; m_rw = rw & live; m_mr = mr & live; m_mw = mw & live;
         m_m2r = mr; m_rd = rd; m_alu = alu; m_wd = wd;
      end
   endtask

   task automatic nop(input logic g, input logic rv, input logic [31:0] rdt);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, g, rv, rdt);
   endtask

   initial begin
      logic v, fl, rw, mr, mw, g, rv;
      logic [4:0]  rd;
      logic [31:0] alu, wd, rdt;
      int kind;
      dif.dmem_gnt = 0; dif.dmem_rvalid = 0; dif.dmem_rdata = '0;
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("reset stall_mem", 32'(stall_mem), 32'd0);
      chk("reset dmem_req", 32'(dif.dmem_req), 32'd0);
      chk("reset RegWrite_wb", 32'(RegWrite_wb), 32'd0);
      chk("reset RegWriteData_wb", RegWriteData_wb, 32'd0);
      chk("reset ALUResult_mem", ALUResult_mem, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // ALU op
      step(1, 0, 1, 0, 0, 5'd5, 32'h1234, 32'd0, 0, 0, 32'd0);
      #1;
      chk("alu ALUResult_mem", ALUResult_mem, 32'h1234);
      chk("alu rdAddr_mem", 32'(rdAddr_mem), 32'd5);
      chk("alu RegWrite_mem", 32'(RegWrite_mem), 32'd1);
      nop(0, 0, 32'd0);
      chk("alu stall", 32'(obs_stall), 32'd0);
      #1;
      chk("alu RegWriteData_wb", RegWriteData_wb, 32'h1234);
      chk("alu RegWrite_wb", 32'(RegWrite_wb), 32'd1);

      // Load: gnt then rvalid
      step(1, 0, 1, 1, 0, 5'd7, 32'h100, 32'd0, 0, 0, 32'd0);
      nop(1, 0, 32'd0);
      chk("load stall c1", 32'(obs_stall), 32'd1);
      chk("load req c1", 32'(obs_req), 32'd1);
      chk("load addr", obs_addr, 32'h100);
      #1 chk("load RegWrite_wb during stall", 32'(RegWrite_wb), 32'd0);
      nop(0, 1, 32'hCAFEBABE);
      chk("load stall c2", 32'(obs_stall), 32'd0);
      #1;
      chk("load RegWriteData_wb", RegWriteData_wb, 32'hCAFEBABE);
      chk("load rdAddr_wb", 32'(rdAddr_wb), 32'd7);
      chk("load RegWrite_wb", 32'(RegWrite_wb), 32'd1);

      // Store with grant held off for 3 cycles
      step(1, 0, 0, 0, 1, 5'd0, 32'h200, 32'h55, 0, 0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         nop(0, 0, 32'd0);
         chk("store stall wait", 32'(obs_stall), 32'd1);
         chk("store req wait", 32'(obs_req), 32'd1);
         chk("store addr wait", obs_addr, 32'h200);
         chk("store wdata wait", obs_wdata, 32'h55);
      end
      nop(1, 0, 32'd0);
      chk("store stall at gnt", 32'(obs_stall), 32'd0);
      #1 chk("store RegWrite_wb", 32'(RegWrite_wb), 32'd0);

      // Flushed load and write to x0
      step(1, 1, 1, 1, 0, 5'd8, 32'h400, 32'd0, 0, 0, 32'd0);
      #1;
      chk("flush RegWrite_mem", 32'(RegWrite_mem), 32'd0);
      chk("flush MemRead_mem", 32'(MemRead_mem), 32'd0);
      step(1, 0, 1, 0, 0, 5'd0, 32'h5, 32'd0, 0, 0, 32'd0);
      chk("flush no req", 32'(obs_req), 32'd0);
      #1 chk("x0 RegWrite_mem", 32'(RegWrite_mem), 32'd0);
      nop(0, 0, 32'd0);
      #1 chk("x0 RegWrite_wb", 32'(RegWrite_wb), 32'd0);

      // Back-to-back loads, zero-wait
      step(1, 0, 1, 1, 0, 5'd3, 32'h40, 32'd0, 0, 0, 32'd0);
      step(1, 0, 1, 1, 0, 5'd4, 32'h44, 32'd0, 1, 1, 32'h11111111);
      chk("b2b stall 1", 32'(obs_stall), 32'd0);
      #1;
      chk("b2b data 1", RegWriteData_wb, 32'h11111111);
      chk("b2b rd 1", 32'(rdAddr_wb), 32'd3);
      nop(1, 1, 32'h22222222);
      chk("b2b stall 2", 32'(obs_stall), 32'd0);
      #1;
      chk("b2b data 2", RegWriteData_wb, 32'h22222222);
      chk("b2b rd 2", 32'(rdAddr_wb), 32'd4);
      chk("b2b rw 2", 32'(RegWrite_wb), 32'd1);

      // Reset while a load waits for its response
      step(1, 0, 1, 1, 0, 5'd9, 32'h300, 32'd0, 0, 0, 32'd0);
      nop(1, 0, 32'd0);
      @(negedge clk);
      rst_n = 1'b0; dif.dmem_gnt = 0; dif.dmem_rvalid = 0;
      #1;
      chk("rst mid stall_mem", 32'(stall_mem), 32'd0);
      chk("rst mid dmem_req", 32'(dif.dmem_req), 32'd0);
      chk("rst mid ALUResult_mem", ALUResult_mem, 32'd0);
      chk("rst mid MemRead_mem", 32'(MemRead_mem), 32'd0);
      chk("rst mid RegWrite_wb", 32'(RegWrite_wb), 32'd0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      nop(0, 1, 32'hDEAD);
      #1;
      chk("stale rvalid RegWrite_wb", 32'(RegWrite_wb), 32'd0);
      chk("stale rvalid RegWriteData_wb", RegWriteData_wb, 32'd0);

      // Randomized stream
      for (int n = 0; n < 600; n++) begin
         kind = $urandom_range(0, 2);
         v    = ($urandom_range(0, 7) != 0);
         fl   = ($urandom_range(0, 7) == 0);
         rw   = (kind != 2);
         mr   = (kind == 1);
         mw   = (kind == 2);
         rd   = 5'($urandom_range(0, 31));
         alu  = $urandom;
         wd   = $urandom;
         g    = exp_req() & ($urandom_range(0, 1) == 1);
         rv   = ($urandom_range(0, 2) == 0);
         rdt  = $urandom;
         step(v, fl, rw, mr, mw, rd, alu, wd, g, rv, rdt);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
